// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one 32-bit memory port between NUM_REQ requesters
//
// Grants at most one request per cycle (zero-latency, combinational grant),
// forwards the winner's request downstream and steers each response back to
// the requester that issued it, MEM_LAT cycles after its grant.
//
// Optional feature macro: MEM_ARB_LOCK_EN (lets a requester hold the port
// for atomic multi-beat sequences via lock_i). Without it lock_i is ignored.
//
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   req_i/lock_i[NUM_REQ]          per-requester request / lock request
//   addr_i/we_i/be_i/wdata_i       per-requester access attributes
//   gnt_o[NUM_REQ]                 one-hot grant (combinational)
//   rvalid_o/err_o[NUM_REQ]        per-requester response valid / error
//   rdata_o[31:0]                  read data, broadcast, qualified by rvalid_o
//   mem_req_o/addr/we/be/wdata     downstream request (zeroed when idle)
//   mem_rvalid_i/err/rdata         downstream response, fixed MEM_LAT latency

module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int MEM_LAT = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ-1:0]       lock_i,
  input  logic [NUM_REQ-1:0][31:0] addr_i,
  input  logic [NUM_REQ-1:0]       we_i,
  input  logic [NUM_REQ-1:0][3:0]  be_i,
  input  logic [NUM_REQ-1:0][31:0] wdata_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       rvalid_o,
  output logic [NUM_REQ-1:0]       err_o,
  output logic [31:0]              rdata_o,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  output logic                     mem_we_o,
  output logic [3:0]               mem_be_o,
  output logic [31:0]              mem_wdata_o,
  input  logic                     mem_rvalid_i,
  input  logic                     mem_err_i,
  input  logic [31:0]              mem_rdata_i
);

  localparam int IW = $clog2(NUM_REQ);

  logic [IW-1:0]              rr_ptr;
  logic [IW-1:0]              winner;
  logic                       any_gnt;
  logic [NUM_REQ-1:0]         elig_req;
  logic [MEM_LAT-1:0]         trk_valid;
  logic [MEM_LAT-1:0][IW-1:0] trk_id;

`ifdef MEM_ARB_LOCK_EN
  logic          locked;
  logic [IW-1:0] lock_owner;

  // While locked, only the owner's request is visible to the arbiter.
  always_comb begin
    elig_req = req_i;
    if (locked) elig_req = req_i & (NUM_REQ'(1) << lock_owner);
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_i;
  assign elig_req    = req_i;
`endif

  // Scan rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first eligible request wins.
  // sum stays below 2*NUM_REQ, so one conditional subtract performs the wrap.
  always_comb begin
    logic [IW:0] sum;
    winner  = '0;
    any_gnt = 1'b0;
    sum     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + k[IW:0];
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!any_gnt && elig_req[sum[IW-1:0]]) begin
        any_gnt = 1'b1;
        winner  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    if (any_gnt) gnt_o[winner] = 1'b1;
  end

  // Idle drives all-zero downstream attributes so no stray write can leak.
  assign mem_req_o   = any_gnt;
  assign mem_addr_o  = any_gnt ? addr_i[winner]  : '0;
  assign mem_we_o    = any_gnt ? we_i[winner]    : 1'b0;
  assign mem_be_o    = any_gnt ? be_i[winner]    : '0;
  assign mem_wdata_o = any_gnt ? wdata_i[winner] : '0;

  // Owner tracker: entry 0 records this cycle's grant, the tail lines up
  // with the response returning MEM_LAT cycles later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_valid <= '0;
      trk_id    <= '0;
    end else begin
      trk_valid[0] <= any_gnt;
      trk_id[0]    <= winner;
      for (int i = 1; i < MEM_LAT; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_id[i]    <= trk_id[i-1];
      end
    end
  end

  // A response with no matching tracker entry is dropped.
  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    if (mem_rvalid_i && trk_valid[MEM_LAT-1]) begin
      rvalid_o[trk_id[MEM_LAT-1]] = 1'b1;
      err_o[trk_id[MEM_LAT-1]]    = mem_err_i;
    end
  end

  assign rdata_o = mem_rdata_i;

`ifdef MEM_ARB_LOCK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      locked     <= 1'b0;
      lock_owner <= '0;
    end else begin
      // Pointer is frozen for the whole locked sequence.
      if (any_gnt && !locked) begin
        rr_ptr <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + IW'(1);
      end
      if (!locked) begin
        if (any_gnt && lock_i[winner]) begin
          locked     <= 1'b1;
          lock_owner <= winner;
        end
      end else if (!lock_i[lock_owner]) begin
        // Owner either granted with lock dropped, or idle with lock dropped.
        locked <= 1'b0;
      end
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr <= '0;
    end else if (any_gnt) begin
      rr_ptr <= (winner == IW'(NUM_REQ-1)) ? '0 : winner + IW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  localparam int NR = 3;
  localparam int ML = 3;

  logic                clk;
  logic                rst_ni;
  logic [NR-1:0]       req_i;
  logic [NR-1:0]       lock_i;
  logic [NR-1:0][31:0] addr_i;
  logic [NR-1:0]       we_i;
  logic [NR-1:0][3:0]  be_i;
  logic [NR-1:0][31:0] wdata_i;
  logic [NR-1:0]       gnt_o;
  logic [NR-1:0]       rvalid_o;
  logic [NR-1:0]       err_o;
  logic [31:0]         rdata_o;
  logic                mem_req_o;
  logic [31:0]         mem_addr_o;
  logic                mem_we_o;
  logic [3:0]          mem_be_o;
  logic [31:0]         mem_wdata_o;
  logic                mem_rvalid_i;
  logic                mem_err_i;
  logic [31:0]         mem_rdata_i;

  mem_port_arbiter #(.NUM_REQ(NR), .MEM_LAT(ML)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .lock_i(lock_i),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .err_o(err_o), .rdata_o(rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: priority pointer, lock state, and a queue of granted
  // ids (-1 = no grant) whose head is the owner of the response due now.
  int m_rr = 0;
  bit m_locked = 0;
  int m_owner = 0;
  int hist[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] req);
    for (int k = 0; k < NR; k++) begin
      int i;
      i = (m_rr + k) % NR;
      if (req[i] && (!m_locked || i == m_owner)) return i;
    end
    return -1;
  endfunction

  task automatic step(input logic [NR-1:0] req, input logic [NR-1:0] lock,
                      input logic rst, input logic mrv, input logic merr,
                      input logic [31:0] a0,
                      output logic [NR-1:0] g, output logic [NR-1:0] rv);
    int w;
    int tail;
    logic [NR-1:0] eg, erv, eer;
    @(negedge clk);
    rst_ni = rst;
    req_i  = req;
    lock_i = lock;
    for (int i = 0; i < NR; i++) begin
      addr_i[i]  = (i == 0) ? a0 : $urandom;
      wdata_i[i] = $urandom;
      we_i[i]    = 1'($urandom_range(0, 1));
      be_i[i]    = 4'($urandom_range(0, 15));
    end
    mem_rvalid_i = mrv;
    mem_err_i    = merr;
    mem_rdata_i  = $urandom;
    #1;
    if (!rst) begin
      m_rr = 0;
      m_locked = 0;
      hist.delete();
    end
    w    = pick(req);
    eg   = (w >= 0) ? (NR'(1) << w) : '0;
    tail = (rst && hist.size() == ML) ? hist[0] : -1;
    erv  = (tail >= 0 && mrv) ? (NR'(1) << tail) : '0;
    eer  = (tail >= 0 && mrv && merr) ? (NR'(1) << tail) : '0;
    chk("gnt", gnt_o, eg);
    chk("mem_req", mem_req_o, (w >= 0));
    chk("mem_addr", mem_addr_o, (w >= 0) ? addr_i[w] : 32'd0);
    chk("mem_we", mem_we_o, (w >= 0) ? we_i[w] : 1'b0);
    chk("mem_be", mem_be_o, (w >= 0) ? be_i[w] : 4'd0);
    chk("mem_wdata", mem_wdata_o, (w >= 0) ? wdata_i[w] : 32'd0);
    chk("rvalid", rvalid_o, erv);
    chk("err", err_o, eer);
    chk("rdata", rdata_o, mem_rdata_i);
    g  = gnt_o;
    rv = rvalid_o;
    if (rst) begin
      hist.push_back(w);
      if (hist.size() > ML) void'(hist.pop_front());
      if (w >= 0 && !m_locked) m_rr = (w + 1) % NR;
`ifdef MEM_ARB_LOCK_EN
      if (!m_locked) begin
        if (w >= 0 && lock[w]) begin
          m_locked = 1;
          m_owner = w;
        end
      end else if ((w == m_owner && !lock[m_owner]) || (!req[m_owner] && !lock[m_owner])) begin
        m_locked = 0;
      end
`endif
    end
  endtask

  logic [NR-1:0] g, rv;
  logic [NR-1:0] alt_exp[4];
  logic [NR-1:0] wrap_exp[6];
  logic [NR-1:0] lock_exp[4];
  logic [NR-1:0] lock_seq[4];

  initial begin
    rst_ni = 1'b0; req_i = '0; lock_i = '0; addr_i = '0; we_i = '0;
    be_i = '0; wdata_i = '0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0; mem_rdata_i = '0;
    alt_exp  = '{3'b001, 3'b010, 3'b001, 3'b010};
    wrap_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`ifdef MEM_ARB_LOCK_EN
    lock_exp = '{3'b001, 3'b001, 3'b001, 3'b010};
`else
    lock_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    lock_seq = '{3'b001, 3'b001, 3'b000, 3'b000};

    // Reset state, with a stray downstream response present.
    step('0, '0, 1'b0, 1'b1, 1'b1, 32'd0, g, rv);
    chk("reset_gnt", g, 3'b000);
    chk("reset_rvalid", rv, 3'b000);
    step('0, '0, 1'b0, 1'b0, 1'b0, 32'd0, g, rv);

    // Single requester, response MEM_LAT cycles later.
    step(3'b001, '0, 1'b1, 1'b1, 1'b0, 32'h100, g, rv);
    chk("single_gnt", g, 3'b001);
    chk("single_addr", mem_addr_o, 32'h100);
    for (int i = 0; i < ML; i++) step('0, '0, 1'b1, 1'b1, 1'b0, 32'd0, g, rv);
    chk("single_rvalid", rv, 3'b001);

    // Contention from a fresh pointer: strict alternation.
    step('0, '0, 1'b0, 1'b0, 1'b0, 32'd0, g, rv);
    for (int i = 0; i < 4; i++) begin
      step(3'b011, '0, 1'b1, 1'b1, 1'b0, $urandom, g, rv);
      chk("contend_gnt", g, alt_exp[i]);
    end
    for (int i = 0; i < ML; i++) step('0, '0, 1'b1, 1'b1, 1'b0, 32'd0, g, rv);

    // Error routed only to requester 1.
    step('0, '0, 1'b0, 1'b0, 1'b0, 32'd0, g, rv);
    step(3'b010, '0, 1'b1, 1'b0, 1'b0, $urandom, g, rv);
    for (int i = 0; i < ML - 1; i++) step('0, '0, 1'b1, 1'b0, 1'b0, 32'd0, g, rv);
    step('0, '0, 1'b1, 1'b1, 1'b1, 32'd0, g, rv);
    chk("errroute_rvalid", rv, 3'b010);
    chk("errroute_err", err_o, 3'b010);

    // Reset while a response is in flight: it must be discarded.
    step(3'b010, '0, 1'b1, 1'b0, 1'b0, $urandom, g, rv);
    step('0, '0, 1'b0, 1'b0, 1'b0, 32'd0, g, rv);
    step('0, '0, 1'b1, 1'b0, 1'b0, 32'd0, g, rv);
    step('0, '0, 1'b1, 1'b1, 1'b0, 32'd0, g, rv);
    chk("midreset_rvalid", rv, 3'b000);
    step(3'b111, '0, 1'b1, 1'b1, 1'b0, $urandom, g, rv);
    chk("midreset_rrptr", g, 3'b001);

    // Wrap over three requesters.
    step('0, '0, 1'b0, 1'b0, 1'b0, 32'd0, g, rv);
    for (int i = 0; i < 6; i++) begin
      step(3'b111, '0, 1'b1, 1'b1, 1'b0, $urandom, g, rv);
      chk("wrap_gnt", g, wrap_exp[i]);
    end

    // Locked burst by requester 0 while requester 1 waits.
    step('0, '0, 1'b0, 1'b0, 1'b0, 32'd0, g, rv);
    for (int i = 0; i < 4; i++) begin
      step(3'b011, lock_seq[i], 1'b1, 1'b1, 1'b0, $urandom, g, rv);
      chk("lock_gnt", g, lock_exp[i]);
    end

    // Randomized traffic including locks, stray responses and resets.
    for (int n = 0; n < 400; n++) begin
      step(NR'($urandom), NR'($urandom), ($urandom_range(0, 49) != 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, g, rv);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single 32-bit processor memory port (req/addr/we/be/wdata out; rvalid/err/rdata back) between NUM_REQ requesters, e.g. the vector core and a hash accelerator. It sits between the requesters and the RAM/hwreg address decode. It grants at most one request per cycle and routes each response back to the requester that issued it. An optional lock lets one requester hold the port for atomic multi-beat sequences.

## Interface
- NUM_REQ, 2, number of requesters; legal range 2..8; ID width IW = $clog2(NUM_REQ)
- MEM_LAT, 1, fixed response latency of the downstream memory in cycles; legal range 1..4
- clk_i  in  1  clock; the block has one clock
- rst_ni  in  1  reset, asynchronous and active-low
- req_i  in  NUM_REQ  per-requester request; held until granted
- lock_i  in  NUM_REQ  per-requester lock request; used only with MEM_ARB_LOCK_EN
- addr_i  in  NUM_REQ x 32  per-requester address
- we_i  in  NUM_REQ  per-requester write enable
- be_i  in  NUM_REQ x 4  per-requester byte enables
- wdata_i  in  NUM_REQ x 32  per-requester write data
- gnt_o  out  NUM_REQ  one-hot grant, combinational
- rvalid_o  out  NUM_REQ  per-requester response valid
- err_o  out  NUM_REQ  per-requester response error
- rdata_o  out  32  read data broadcast to all requesters; qualified by rvalid_o
- mem_req_o, mem_addr_o[31:0], mem_we_o, mem_be_o[3:0], mem_wdata_o[31:0]  out  downstream request
- mem_rvalid_i, mem_err_i, mem_rdata_i[31:0]  in  downstream response

## Operation
- Downstream port accepts every request and returns mem_rvalid_i exactly MEM_LAT cycles later. There is no backpressure.
- Arbitration:
  - rr_ptr (IW bits) names the highest-priority requester.
  - The winner is the first i with req_i[i]=1, scanning rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - gnt_o[winner]=1. mem_req_o=1. Downstream addr/we/be/wdata are muxed from the winner.
- rr_ptr update: on a grant, rr_ptr <= (winner+1) mod NUM_REQ, with wrap at NUM_REQ-1 -> 0. With no request, rr_ptr holds.
- Owner tracking:
  - A shift register of MEM_LAT entries holds {valid, id}.
  - Entry 0 is loaded each cycle with {mem_req_o, winner}. Entries shift toward entry MEM_LAT-1.
  - When mem_rvalid_i=1 and the tail entry is valid: rvalid_o[tail.id]=1 and err_o[tail.id]=mem_err_i.
  - mem_rvalid_i with an invalid tail entry is dropped. No rvalid_o is raised.
- Idle state: mem_req_o=0 and the downstream data outputs are 0, so stray writes cannot occur.
- Requester rule: address and data must stay stable while req_i=1 and gnt_o=0. The arbiter does not check this.
- A requester may re-request in the cycle after its grant. Back-to-back requests are allowed, but round-robin forces alternation while others are waiting.

## Timing
- Reset values:
  - gnt_o=0, mem_req_o=0, rvalid_o=0, err_o=0 (as long as req_i=0).
  - rr_ptr=0, all tracker entries invalid, lock inactive.
- Grant is zero-latency: the request and the grant occur in the same cycle, combinational from req_i and state.
- Response appears exactly MEM_LAT cycles after the grant cycle. rvalid_o and err_o are combinational from mem_rvalid_i, mem_err_i and the tracker tail.
- Throughput: one access per cycle total.
- Reset mid-operation: tracker is cleared immediately. In-flight responses are discarded and no rvalid_o is raised after reset release.
- Simultaneous events: arbitration and tracker shift happen in the same cycle. A grant in the cycle where a response returns is legal.

## Configuration
- Macro: MEM_ARB_LOCK_EN.
- Defined:
  - If the granted requester has lock_i=1 in its grant cycle, lock_owner <= winner and locked <= 1.
  - While locked, only lock_owner can be granted. Other requests wait with gnt_o=0, and rr_ptr does not advance.
  - The lock releases on a cycle where lock_owner is granted with lock_i=0, or where lock_owner has req_i=0 and lock_i=0.
  - Reset clears the lock.
- Undefined: lock_i is ignored (port kept for a stable interface). No lock state exists; pure round-robin.

## Test plan
- Single requester: req_i=2'b01, addr_i[0]=0x100, we=0, MEM_LAT=1 -> gnt_o=01, mem_addr_o=0x100 in the same cycle; next cycle rvalid_o=01, rdata_o=mem_rdata_i.
- Contention: req_i=2'b11 held for 4 cycles after reset -> grants 01,10,01,10; four rvalid_o pulses in the same order, each one cycle after its grant.
- Error routing: grant to requester 1, then mem_err_i=1 with mem_rvalid_i -> err_o=10, rvalid_o=10; requester 0 sees nothing.
- Reset mid-flight (MEM_LAT=3): grant at cycle t, rst_ni low at t+1, released at t+2, mem_rvalid_i=1 at t+3 -> rvalid_o stays 0; rr_ptr=0.
- Lock (MEM_ARB_LOCK_EN): requester 0 issues 3 locked accesses (lock_i=1,1,0) while req_i[1]=1 throughout -> grants 01,01,01, then 10; without the macro -> 01,10,01,10.
- Wrap (NUM_REQ=3): all three requesting continuously for 6 cycles -> grants 0,1,2,0,1,2.
